// File: rtl/load_store_unit_pkg.sv
// Shared funct3 codes and FSM state encoding for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response channel and memory-side command/read-return
// channel of the load/store unit.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, busy, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, busy, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_bus_if #(
  parameter int ADDR_W = 14
);
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-3:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_wdata;
  logic              bus_rvalid;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Width/sign logic: store lane placement and strobes, load extraction and
// extension, and request legality.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr, 3'b000};

  always_comb begin
    o_wstrb      = 4'b0000;
    o_wdata      = 32'h0;
    o_rdata      = 32'h0;
    o_misaligned = 1'b0;
    o_illegal    = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_wstrb = 4'b0001 << i_addr;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      F3_H: begin
        o_wstrb      = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{w_shifted[15]}}, w_shifted[15:0]};
        o_misaligned = i_addr[0];
      end
      F3_W: begin
        o_wstrb      = 4'b1111;
        o_wdata      = i_wdata;
        o_rdata      = w_shifted;
        o_misaligned = |i_addr;
      end
      // Unsigned widths exist only for loads.
      F3_BU: begin
        o_rdata   = {24'h0, w_shifted[7:0]};
        o_illegal = i_store;
      end
      F3_HU: begin
        o_rdata      = {16'h0, w_shifted[15:0]};
        o_misaligned = i_addr[0];
        o_illegal    = i_store;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: FSM, request registers and read-timeout counter around
// the combinational lane aligner.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic      clk,
  input  logic      rst,
  lsu_req_if.slave  req,
  lsu_bus_if.master bus
);

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic              r_store;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [7:0]        r_tcount;

  logic        w_idle;
  logic        w_accept;
  logic        w_bad;
  logic        w_store;
  logic [2:0]  w_funct3;
  logic [1:0]  w_lane;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_tmax;
  logic        w_unused;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && req.req_valid;
  // In IDLE the aligner judges the live request; afterwards it works on the
  // latched request so the returning read word is extracted correctly.
  assign w_store  = w_idle ? req.req_store       : r_store;
  assign w_funct3 = w_idle ? req.req_funct3      : r_funct3;
  assign w_lane   = w_idle ? req.req_addr[1:0]   : r_addr[1:0];
  assign w_bad    = w_misaligned || w_illegal;
  assign w_tmax   = (r_tcount == TMAX);
  assign w_unused = ^req.req_addr[31:ADDR_W];

  lsu_lane_align u_align (
    .i_store      (w_store),
    .i_funct3     (w_funct3),
    .i_addr       (w_lane),
    .i_wdata      (req.req_wdata),
    .i_rdata      (bus.bus_rdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req.req_valid) w_next = w_bad ? DONE : ISSUE;
      ISSUE:   if (bus.bus_ready) w_next = r_store ? DONE : WAIT_R;
      WAIT_R:  if (bus.bus_rvalid || w_tmax) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, read capture and timeout counter; rvalid beats a
  // simultaneous timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wstrb  <= 4'b0000;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
      r_tcount <= 8'h0;
    end else begin
      if (w_accept) begin
        r_store  <= req.req_store;
        r_funct3 <= req.req_funct3;
        r_addr   <= req.req_addr[ADDR_W-1:0];
        r_wstrb  <= req.req_store ? w_wstrb : 4'b0000;
        r_wdata  <= req.req_store ? w_wdata : 32'h0;
        r_rdata  <= 32'h0;
        r_err    <= w_bad;
      end
      if (r_state == ISSUE && bus.bus_ready) begin
        r_tcount <= 8'h0;
      end
      if (r_state == WAIT_R) begin
        if (bus.bus_rvalid)  r_rdata  <= w_rdata;
        else if (w_tmax)     r_err    <= 1'b1;
        else                 r_tcount <= r_tcount + 8'h1;
      end
    end
  end

  assign req.req_ready  = w_idle;
  assign req.busy       = !w_idle;
  assign req.resp_valid = (r_state == DONE);
  assign req.resp_err   = (r_state == DONE) && r_err;
  assign req.resp_rdata = (r_state == DONE) ? r_rdata : 32'h0;

  assign bus.bus_valid  = (r_state == ISSUE);
  assign bus.bus_we     = (r_state == ISSUE) && r_store;
  assign bus.bus_addr   = r_addr[ADDR_W-1:2];
  assign bus.bus_wstrb  = (r_state == ISSUE) ? r_wstrb : 4'b0000;
  assign bus.bus_wdata  = r_wdata;

endmodule
